// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and sequencer state
// encodings, used by the sequencer, the datapath and the bench.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_ADDI = 4'b1010;
  localparam logic [3:0] OP_SUBI = 4'b1011;
  localparam logic [3:0] OP_BR   = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1110;
  localparam logic [3:0] OP_OUT  = 4'b1111;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 11;
  localparam int TGT_LSB = 8;

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Sequencer-side bus: program ROM port plus instruction/strobe outputs and the
// zero flag returned by the datapath.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic [INST_W-1:0] ir;
  logic              exec_en;
  logic              wb_en;
  logic              out_en;
  logic              zero_flag;

  modport master (
    output rom_addr, ir, exec_en, wb_en, out_en,
    input  rom_inst, zero_flag
  );

  modport slave (
    input  rom_addr, ir, exec_en, wb_en, out_en,
    output rom_inst, zero_flag
  );
endinterface

// File: rtl/opcode_decode.sv
// Combinational opcode classifier; undefined opcodes decode as nop (all flags low).
module opcode_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op_i,
  output logic       is_wb_o,
  output logic       is_out_o,
  output logic       is_jmp_o,
  output logic       is_br_o
);

  always_comb begin
    is_wb_o  = 1'b0;
    is_out_o = 1'b0;
    is_jmp_o = 1'b0;
    is_br_o  = 1'b0;
    case (op_i)
      OP_LOAD, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_MOV: is_wb_o = 1'b1;
      OP_OUT:  is_out_o = 1'b1;
      OP_JMP:  is_jmp_o = 1'b1;
      OP_BR:   is_br_o  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Three-cycle FETCH/EXEC/WB controller owning pc and ir; strobes are decodes of
// registered state so each fires for exactly one cycle per instruction.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  fetch_sequencer_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic              step_mode_q, step_mode_d;
  logic              br_taken_q, br_taken_d;

  logic is_wb, is_out, is_jmp, is_br;
  logic [ADDR_W-1:0] target;

  opcode_decode u_dec (
    .op_i     (ir_q[OP_MSB:OP_LSB]),
    .is_wb_o  (is_wb),
    .is_out_o (is_out),
    .is_jmp_o (is_jmp),
    .is_br_o  (is_br)
  );

  assign target = ir_q[TGT_MSB:TGT_LSB];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    step_mode_d = step_mode_q;
    br_taken_d  = br_taken_q;
    case (state_q)
      S_HALT: begin
        // run wins over step when both arrive together
        if (run) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end
      end
      S_FETCH: begin
        ir_d    = bus.rom_inst;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        br_taken_d = bus.zero_flag;
        state_d    = S_WB;
      end
      S_WB: begin
        if (is_jmp || (is_br && br_taken_q)) pc_d = target;
        else                                 pc_d = pc_q + ADDR_W'(1);
        state_d = (!run || step_mode_q) ? S_HALT : S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HALT;
      pc_q        <= '0;
      ir_q        <= '0;
      step_mode_q <= 1'b0;
      br_taken_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      step_mode_q <= step_mode_d;
      br_taken_q  <= br_taken_d;
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.ir       = ir_q;
  assign bus.exec_en  = (state_q == S_EXEC);
  assign bus.wb_en    = (state_q == S_WB) && is_wb;
  assign bus.out_en   = (state_q == S_WB) && is_out;
  assign pc           = pc_q;
  assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: directed programs push expected per-instruction records, a
// negedge monitor pops one per executed instruction and compares.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, step, zf;
  logic [3:0]  pc;
  logic        halted;
  logic [15:0] rom [16];

  fetch_sequencer_if bus ();
  assign bus.rom_inst  = rom[bus.rom_addr];
  assign bus.zero_flag = zf;

  fetch_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .step   (step),
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  pc;
    logic [15:0] ir;
    logic        wb;
    logic        out;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_out = -1;
  logic [4:0]  br_pc   = 5'h1f;
  logic        br_zf   = 1'b0;
  logic        pend    = 1'b0;
  logic [3:0]  cap_pc;
  logic [15:0] cap_ir;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Monitor: capture pc/ir in EXEC, compare the whole record in the following WB cycle.
  always @(negedge clk) begin
    if ((bus.wb_en || bus.out_en) && !pend) begin
      n_tests++;
      n_fail++;
      $display("FAIL stray_strobe: got wb=%b out=%b outside WB, want 0", bus.wb_en, bus.out_en);
    end
    if (bus.out_en) begin
      if (last_out >= 0) check("out_period", cyc - last_out, 9);
      last_out = cyc;
    end
    if (bus.exec_en) begin
      check("exec_overlap", {30'd0, bus.wb_en, bus.out_en}, 0);
      cap_pc = pc;
      cap_ir = bus.ir;
      pend   = 1'b1;
    end else if (pend) begin
      pend = 1'b0;
      if (!halted) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_instr: got pc=%0d ir=%h, want none", cap_pc, cap_ir);
        end else begin
          e = exp_q.pop_front();
          check("instr", {10'd0, cap_pc, cap_ir, bus.wb_en, bus.out_en},
                         {10'd0, e.pc, e.ir, e.wb, e.out});
        end
      end
    end
  end

  task automatic push(input logic [3:0] p, input logic wb, input logic o);
    exp_q.push_back({p, rom[p], wb, o});
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; step = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_out = -1;
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!halted && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", {31'd0, halted}, 1);
  endtask

  // Free-run until n instructions reached EXEC, drop run during the last one.
  task automatic run_n(input int n, input logic with_step);
    int k = 0;
    int c = 0;
    @(negedge clk);
    run = 1'b1; step = with_step;
    while (k < n && c < 2000) begin
      @(negedge clk);
      step = 1'b0;
      c++;
      zf = ({1'b0, pc} == br_pc && bus.exec_en) ? br_zf : ~br_zf;
      if (bus.exec_en) begin
        k++;
        if (k == n) run = 1'b0;
      end
    end
    run = 1'b0;
    if (k < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_timeout: got %0d instructions, want %0d", k, n);
    end
    wait_halt();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rst = 1'b1; run = 1'b0; step = 1'b0; zf = 1'b0;
    fill_nop();

    // 1: counting loop with out and jmp back
    rom[0] = 16'hA40F; rom[1] = 16'hB401; rom[2] = 16'hF080; rom[3] = 16'h8100;
    do_reset();
    check("rst_pc", {28'd0, pc}, 0);
    check("rst_ir", {16'd0, bus.ir}, 0);
    check("rst_halted", {31'd0, halted}, 1);
    check("rst_strobes", {29'd0, bus.exec_en, bus.wb_en, bus.out_en}, 0);
    check("rst_rom_addr", {28'd0, bus.rom_addr}, 0);
    push(0, 1, 0); push(1, 1, 0); push(2, 0, 1); push(3, 0, 0);
    for (int i = 0; i < 2; i++) begin
      push(1, 1, 0); push(2, 0, 1); push(3, 0, 0);
    end
    run_n(10, 1'b0);
    check("t1_halt_pc", {28'd0, pc}, 1);

    // 2: br at 6 -> 10 taken, then not taken
    fill_nop();
    rom[6] = 16'hCA00;
    br_pc = 5'd6; br_zf = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) push(4'(i), 0, 0);
    push(10, 0, 0);
    run_n(8, 1'b0);
    check("t2_taken_pc", {28'd0, pc}, 11);
    br_zf = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) push(4'(i), 0, 0);
    run_n(8, 1'b0);
    check("t2_nottaken_pc", {28'd0, pc}, 8);
    br_pc = 5'h1f;

    // 3: pc wrap 15 -> 0
    fill_nop();
    do_reset();
    for (int i = 0; i < 16; i++) push(4'(i), 0, 0);
    push(0, 0, 0);
    run_n(17, 1'b0);
    check("t3_wrap_pc", {28'd0, pc}, 1);

    // 4: single step, second step pulse in EXEC ignored
    rom[0] = 16'hA40F; rom[1] = 16'hB401; rom[2] = 16'hF080; rom[3] = 16'h8100;
    do_reset();
    push(0, 1, 0);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    check("t4_fetch_not_halted", {31'd0, halted}, 0);
    @(negedge clk);
    check("t4_exec_en", {31'd0, bus.exec_en}, 1);
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk);
    check("t4_halted_after_3", {31'd0, halted}, 1);
    check("t4_pc", {28'd0, pc}, 1);
    repeat (6) @(negedge clk);
    check("t4_still_halted", {27'd0, halted, pc}, {27'd0, 1'b1, 4'd1});

    // 5: drop run in FETCH of the add at pc 4, then run+step together
    fill_nop();
    rom[4] = 16'h2440;
    do_reset();
    for (int i = 0; i < 4; i++) push(4'(i), 0, 0);
    push(4, 1, 0);
    @(negedge clk); run = 1'b1;
    c = 0;
    while (pc != 4'd4 && c < 100) begin
      @(negedge clk);
      c++;
    end
    run = 1'b0;
    check("t5_reached_pc4", {28'd0, pc}, 4);
    wait_halt();
    check("t5_halt_pc", {28'd0, pc}, 5);
    push(5, 0, 0); push(6, 0, 0); push(7, 0, 0);
    run_n(3, 1'b1);
    check("t5_freerun_pc", {28'd0, pc}, 8);

    // 6: reset during EXEC
    do_reset();
    push(0, 0, 0); push(1, 0, 0); push(2, 0, 0);
    run_n(3, 1'b0);
    check("t6_pre_pc", {28'd0, pc}, 3);
    @(negedge clk); run = 1'b1;
    c = 0;
    while (!bus.exec_en && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("t6_in_exec", {31'd0, bus.exec_en}, 1);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    check("t6_pc", {28'd0, pc}, 0);
    check("t6_ir", {16'd0, bus.ir}, 0);
    check("t6_halted", {31'd0, halted}, 1);
    check("t6_strobes", {29'd0, bus.exec_en, bus.wb_en, bus.out_en}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
